rom_sequencer: RTL and testbench



---
 rtl/rom_seq_pkg.sv | 9 +
 rtl/tick_gen.sv | 18 +
 rtl/rom_sequencer.sv | 70 +++++++
 tb/tb_rom_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rom_seq_pkg.sv
// rom_seq_pkg: shared types and constants for the ROM address sequencer
package rom_seq_pkg;
  localparam int ADR_W = 3;
  localparam int DATA_W = 4;
  localparam int SUM_W = ADR_W + DATA_W;
  localparam int LAST_UP = 7;
  localparam int LAST_DN = 0;
  typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/tick_gen.sv
// tick_gen: prescaler that pulses tick every TICK_DIV enabled cycles
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] TOP = W'(TICK_DIV - 1);
  logic [W-1:0] cnt;
  assign tick = en && cnt == TOP;
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= tick ? '0 : cnt + 1'b1;
endmodule

// File: rtl/rom_sequencer.sv
// rom_sequencer: steps a ROM address at a prescaled rate, capturing and summing each word
module rom_sequencer #(
  parameter int TICK_DIV = 50_000_000,
  parameter int ADR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    dir,
  input  logic                    loop,
  output logic [ADR_W-1:0]        rom_adr,
  input  logic [DATA_W-1:0]       rom_data,
  output logic [DATA_W-1:0]       data_q,
  output logic                    data_valid,
  output logic [ADR_W+DATA_W-1:0] sum,
  output logic                    busy,
  output logic                    done
);
  import rom_seq_pkg::*;
  localparam int SW = ADR_W + DATA_W;
  state_t state, state_n;
  logic dir_q, tick, capture, accept, last, first;
  logic [ADR_W-1:0] home;
  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .en(state == RUN),
    .clr(state != RUN),
    .tick(tick)
  );
  assign busy = state == RUN;
  // home is where a pass starts; the opposite end is the last location
  always_comb begin
    home = dir_q ? '1 : '0;
    first = rom_adr == home;
    last = rom_adr == ~home;
    accept = state == IDLE && start && !stop;
    capture = state == RUN && tick && !stop;
    state_n = accept ? RUN
            : (state == RUN && (stop || (capture && last && !loop))) ? IDLE
            : state;
  end
  // stepping past the last location lands on home, so wrap and return share one increment
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rom_adr <= '0;
      data_q <= '0;
      sum <= '0;
      data_valid <= 1'b0;
      done <= 1'b0;
      dir_q <= 1'b0;
    end else begin
      state <= state_n;
      data_valid <= capture;
      done <= capture && last;
      if (accept) begin
        rom_adr <= dir ? '1 : '0;
        dir_q <= dir;
        sum <= '0;
      end else if (capture) begin
        data_q <= rom_data;
        sum <= (first ? '0 : sum) + SW'(rom_data);
        rom_adr <= dir_q ? rom_adr - 1'b1 : rom_adr + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_rom_sequencer.sv
// tb_rom_sequencer: directed checks of the sequencer at TICK_DIV=4 and TICK_DIV=1
module tb_rom_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start4 = 1'b0, stop4 = 1'b0, dir4 = 1'b0, loop4 = 1'b0;
  logic start1 = 1'b0, stop1 = 1'b0, dir1 = 1'b0, loop1 = 1'b0;
  logic [2:0] adr4, adr1;
  logic [3:0] rd4, rd1, dq4, dq1;
  logic [6:0] sum4, sum1;
  logic dv4, dv1, busy4, busy1, done4, done1;
  logic [3:0] rom [8] = '{4'd0, 4'd13, 4'd10, 4'd8, 4'd4, 4'd11, 4'd2, 4'd1};
  int up_sum [8] = '{0, 13, 23, 31, 35, 46, 48, 49};
  int dn_sum [8] = '{1, 3, 14, 18, 26, 36, 49, 49};
  int n_cmp = 0;
  int n_err = 0;
  assign rd4 = rom[adr4];
  assign rd1 = rom[adr1];
  always #5 clk = ~clk;
  rom_sequencer #(.TICK_DIV(4), .ADR_W(3), .DATA_W(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .stop(stop4), .dir(dir4), .loop(loop4),
    .rom_adr(adr4), .rom_data(rd4), .data_q(dq4), .data_valid(dv4), .sum(sum4),
    .busy(busy4), .done(done4)
  );
  rom_sequencer #(.TICK_DIV(1), .ADR_W(3), .DATA_W(4)) u1 (
    .clk(clk), .rst(rst), .start(start1), .stop(stop1), .dir(dir1), .loop(loop1),
    .rom_adr(adr1), .rom_data(rd1), .data_q(dq1), .data_valid(dv1), .sum(sum1),
    .busy(busy1), .done(done1)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic wait_dv4(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!dv4 && n < 20);
    chk("dv4_seen", int'(dv4), 1);
  endtask
  task automatic check_idle4(input string tag);
    chk({tag, "_adr"}, int'(adr4), 0);
    chk({tag, "_dq"}, int'(dq4), 0);
    chk({tag, "_sum"}, int'(sum4), 0);
    chk({tag, "_dv"}, int'(dv4), 0);
    chk({tag, "_busy"}, int'(busy4), 0);
    chk({tag, "_done"}, int'(done4), 0);
  endtask
  task automatic pass4(input logic d, input int poke);
    int n, idx, es;
    start4 = 1'b1; dir4 = d; loop4 = 1'b0;
    step();
    start4 = 1'b0;
    chk("pass_busy", int'(busy4), 1);
    chk("pass_home", int'(adr4), d ? 7 : 0);
    for (int i = 0; i < 8; i++) begin
      if (i == poke) begin
        start4 = 1'b1;
        dir4 = ~d;
      end
      wait_dv4(n);
      start4 = 1'b0;
      dir4 = d;
      idx = d ? 7 - i : i;
      es = d ? dn_sum[i] : up_sum[i];
      chk("pass_gap", n, 4);
      chk("pass_dq", int'(dq4), int'(rom[idx]));
      chk("pass_sum", int'(sum4), es);
      chk("pass_done", int'(done4), i == 7 ? 1 : 0);
    end
    step();
    chk("end_busy", int'(busy4), 0);
    chk("end_done", int'(done4), 0);
    chk("end_dv", int'(dv4), 0);
    chk("end_adr", int'(adr4), d ? 7 : 0);
  endtask
  initial begin
    int n;
    step();
    step();
    rst = 1'b0;
    check_idle4("rst");
    chk("rst1_busy", int'(busy1), 0);
    pass4(1'b0, 5);
    pass4(1'b1, 5);
    start4 = 1'b1; stop4 = 1'b1;
    step();
    chk("ss_busy_a", int'(busy4), 0);
    step();
    chk("ss_busy_b", int'(busy4), 0);
    start4 = 1'b0; stop4 = 1'b0;
    start4 = 1'b1; dir4 = 1'b0;
    step();
    start4 = 1'b0;
    for (int i = 0; i < 3; i++) wait_dv4(n);
    chk("stop_pre_dq", int'(dq4), 10);
    chk("stop_pre_adr", int'(adr4), 3);
    step(); step(); step();
    stop4 = 1'b1;
    step();
    stop4 = 1'b0;
    chk("stop_dv", int'(dv4), 0);
    chk("stop_done", int'(done4), 0);
    chk("stop_dq", int'(dq4), 10);
    chk("stop_sum", int'(sum4), 23);
    chk("stop_busy", int'(busy4), 0);
    chk("stop_adr", int'(adr4), 3);
    for (int i = 0; i < 6; i++) step();
    chk("stop_quiet_dv", int'(dv4), 0);
    start4 = 1'b1;
    step();
    start4 = 1'b0;
    wait_dv4(n);
    wait_dv4(n);
    rst = 1'b1;
    step();
    check_idle4("mrst");
    step(); step();
    rst = 1'b0;
    check_idle4("mrst_hold");
    start1 = 1'b1; loop1 = 1'b1; dir1 = 1'b0;
    step();
    start1 = 1'b0;
    chk("l_busy", int'(busy1), 1);
    step();
    for (int k = 0; k < 16; k++) begin
      chk("l_dv", int'(dv1), 1);
      chk("l_dq", int'(dq1), int'(rom[k % 8]));
      chk("l_sum", int'(sum1), up_sum[k % 8]);
      chk("l_done", int'(done1), k % 8 == 7 ? 1 : 0);
      if (k == 8) loop1 = 1'b0;
      step();
    end
    chk("l_end_dv", int'(dv1), 0);
    chk("l_end_busy", int'(busy1), 0);
    chk("l_end_adr", int'(adr1), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
